ex_muldiv: RTL and testbench

Parametrised multi-cycle execution unit for the RV32M/RV64M multiply-divide instructions, sitting beside the single-cycle ALU in the EX stage. It accepts one operation at a time from id_ex, raises a hold flag to ctrl while it works, and returns a registered result with rd address and write enable for ex_mem. It extends the EX stage with iterative arithmetic, a start/busy/valid handshake, flush abort and configurable width and multiplier mode.

---
 rtl/ex_muldiv_pkg.sv | 28 ++
 rtl/ex_muldiv_div_core.sv | 62 ++++++
 rtl/ex_muldiv.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared RV32M/RV64M decode constants, hold encodings and FSM state type for ex_muldiv.
package ex_muldiv_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic HoldEnable  = 1'b1;
    localparam logic HoldDisable = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle (W cycles after start).
// done is combinational on the last step; quotient/remainder carry that step's result.
module ex_div_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(W);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [W-1:0]  dsr;
    logic [W:0]    shifted;
    logic [W-1:0]  diff;
    logic          ge;

    always_comb begin
        shifted   = {rem, quo[W-1]};
        ge        = (shifted >= {1'b0, dsr});
        // When ge holds the true difference is below dsr, so W bits suffice.
        diff      = shifted[W-1:0] - dsr;
        remainder = ge ? diff : shifted[W-1:0];
        quotient  = {quo[W-2:0], ge};
        done      = busy && (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dsr  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            quo  <= dividend;
            rem  <= '0;
            dsr  <= divisor;
        end else if (busy) begin
            quo <= quotient;
            rem <= remainder;
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV M-extension execution unit: iterative or array multiply, restoring divide, flush abort.
// Result registered in DONE; hold_flag_o stalls ctrl from issue until the result cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit MUL_ITER = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       op1_i,
    input  logic [XLEN-1:0]       op2_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  hold_flag_o,
    output logic                  valid_o,
    output logic [XLEN-1:0]       result_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  regs_wen_o
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t             state;
    logic [1:0]            f3_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  neg_q;
    logic [XLEN-1:0]       mcand_q;
    logic [2*XLEN-1:0]     acc_q;
    logic [CNT_W-1:0]      cnt_q;

    logic            sgn1, sgn2, neg1, neg2, res_neg, is_div;
    logic            div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] abs1, abs2, special_res;

    always_comb begin
        sgn1 = (funct3_i == INST_MULH) || (funct3_i == INST_MULHSU) ||
               (funct3_i == INST_DIV)  || (funct3_i == INST_REM);
        sgn2 = (funct3_i == INST_MULH) || (funct3_i == INST_DIV) || (funct3_i == INST_REM);
        neg1 = sgn1 & op1_i[XLEN-1];
        neg2 = sgn2 & op2_i[XLEN-1];
        abs1 = neg1 ? -op1_i : op1_i;
        abs2 = neg2 ? -op2_i : op2_i;
        // Remainder follows the dividend; everything else is the product/quotient sign.
        res_neg  = (funct3_i == INST_REM) ? neg1 : (neg1 ^ neg2);
        is_div   = funct3_i[2];
        div_zero = (op2_i == '0);
        div_ovf  = sgn2 && (op1_i == SMIN) && (op2_i == '1);
        special  = is_div && (div_zero || div_ovf);
        if (div_zero) begin
            special_res = funct3_i[1] ? op1_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : op1_i;
        end
        accept = (state == S_IDLE) && start_i && !flush_i;
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_step, prod_arr, prod_mag, prod_res;
    logic              mul_last;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, ({XLEN{acc_q[0]}} & mcand_q)};
        acc_step = {mul_sum, acc_q[XLEN-1:1]};
        prod_arr = {{XLEN{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        prod_mag = MUL_ITER ? acc_step : prod_arr;
        prod_res = neg_q ? -prod_mag : prod_mag;
        mul_last = !MUL_ITER || (cnt_q == CNT_W'(XLEN - 1));
    end

    logic            div_start, div_done;
    logic [XLEN-1:0] div_quo, div_rem;

    assign div_start = accept && is_div && !special;

    ex_div_core #(
        .W(XLEN)
    ) u_div_core (
        .clk      (clk),
        .rst      (rstn),
        .start    (div_start),
        .abort    (flush_i),
        .dividend (abs1),
        .divisor  (abs2),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= S_IDLE;
            f3_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else if (flush_i && (state != S_IDLE)) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        f3_q    <= funct3_i[1:0];
                        rd_q    <= rd_addr_i;
                        neg_q   <= res_neg;
                        mcand_q <= abs1;
                        acc_q   <= {{XLEN{1'b0}}, abs2};
                        cnt_q   <= '0;
                        if (special) begin
                            state     <= S_DONE;
                            result_o  <= special_res;
                            rd_addr_o <= rd_addr_i;
                        end else begin
                            state <= is_div ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        state     <= S_DONE;
                        result_o  <= (f3_q == 2'b00) ? prod_res[XLEN-1:0] : prod_res[2*XLEN-1:XLEN];
                        rd_addr_o <= rd_q;
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        state     <= S_DONE;
                        result_o  <= f3_q[1] ? (neg_q ? -div_rem : div_rem)
                                             : (neg_q ? -div_quo : div_quo);
                        rd_addr_o <= rd_q;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = (state != S_IDLE);
    assign valid_o     = (state == S_DONE);
    assign regs_wen_o  = valid_o;
    assign hold_flag_o = ((state == S_MUL) || (state == S_DIV) || ((state == S_IDLE) && start_i))
                         ? HoldEnable : HoldDisable;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: iterative and array-multiplier instances share stimulus, checked against 64-bit arithmetic.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  rd_addr = '0;

    logic        busy_i, hold_i, valid_i, regs_wen_i;
    logic [31:0] result_i;
    logic [4:0]  rd_addr_i;
    logic        busy_a, hold_a, valid_a, regs_wen_a;
    logic [31:0] result_a;
    logic [4:0]  rd_addr_a;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .MUL_ITER(1'b1)) dut_iter (
        .clk(clk), .rstn(rst), .start_i(start), .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
        .rd_addr_i(rd_addr), .flush_i(flush), .busy_o(busy_i), .hold_flag_o(hold_i),
        .valid_o(valid_i), .result_o(result_i), .rd_addr_o(rd_addr_i), .regs_wen_o(regs_wen_i)
    );

    ex_muldiv #(.XLEN(32), .MUL_ITER(1'b0)) dut_arr (
        .clk(clk), .rstn(rst), .start_i(start), .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
        .rd_addr_i(rd_addr), .flush_i(flush), .busy_o(busy_a), .hold_flag_o(hold_a),
        .valid_o(valid_a), .result_o(result_a), .rd_addr_o(rd_addr_a), .regs_wen_o(regs_wen_a)
    );

    typedef struct {
        int          n_i, n_a, cyc_i, cyc_a, proto_bad;
        logic [31:0] res_i, res_a, last_i, last_a;
        logic [4:0]  rd_i, rd_a;
    } obs_t;

    // Reference: RISC-V M semantics via 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Cycle (counted from the accept edge T) in which valid_o is expected.
    function automatic int exp_cycle(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit iter);
        bit sdiv;
        if (f[2]) begin
            sdiv = (f == 3'd4) || (f == 3'd6);
            if (b == 0 || (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
            return 33;
        end
        return iter ? 33 : 2;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    task automatic exec_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int pulse_at, output obs_t o);
        int ce_i, ce_a;
        o = '{default: 0};
        ce_i = exp_cycle(f, a, b, 1'b1);
        ce_a = exp_cycle(f, a, b, 1'b0);
        @(negedge clk);
        start = 1'b1; funct3 = f; op1 = a; op2 = b; rd_addr = rd;
        #1;
        if (hold_i !== 1'b1 || hold_a !== 1'b1) o.proto_bad++;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom()); op1 = $urandom(); op2 = $urandom(); rd_addr = 5'($urandom());
        for (int k = 1; k <= 36; k++) begin
            if (valid_i === 1'b1) begin o.n_i++; o.cyc_i = k; o.res_i = result_i; o.rd_i = rd_addr_i; end
            if (valid_a === 1'b1) begin o.n_a++; o.cyc_a = k; o.res_a = result_a; o.rd_a = rd_addr_a; end
            if (regs_wen_i !== valid_i || regs_wen_a !== valid_a) o.proto_bad++;
            if (hold_i !== (k < ce_i) || hold_a !== (k < ce_a)) o.proto_bad++;
            if (busy_i !== (k <= ce_i) || busy_a !== (k <= ce_a)) o.proto_bad++;
            start = (k == pulse_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        o.last_i = result_i;
        o.last_a = result_a;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy_i, hold_i, valid_i, regs_wen_i, busy_a, hold_a, valid_a, regs_wen_a} !== 8'h00) begin
            fails++;
            $display("FAIL reset_ctrl got=%b%b%b%b %b%b%b%b exp=all 0", busy_i, hold_i, valid_i, regs_wen_i,
                     busy_a, hold_a, valid_a, regs_wen_a);
        end
        checks++;
        if (result_i !== 32'd0 || result_a !== 32'd0 || rd_addr_i !== 5'd0 || rd_addr_a !== 5'd0) begin
            fails++;
            $display("FAIL reset_data got=%h/%h rd=%0d/%0d exp=0", result_i, result_a, rd_addr_i, rd_addr_a);
        end
        rst = 1'b0;
    endtask

    task automatic check_ops(input string tag, input logic [2:0] fs[], input logic [31:0] as[],
                             input logic [31:0] bs[], input int pulse_at);
        obs_t o;
        logic [31:0] e;
        logic [4:0]  rd;
        for (int n = 0; n < fs.size(); n++) begin
            rd = 5'($urandom_range(1, 31));
            e  = ref_model(fs[n], as[n], bs[n]);
            exec_op(fs[n], as[n], bs[n], rd, pulse_at, o);
            checks++;
            if (o.n_i != 1 || o.n_a != 1 || o.cyc_i != exp_cycle(fs[n], as[n], bs[n], 1'b1) ||
                o.cyc_a != exp_cycle(fs[n], as[n], bs[n], 1'b0)) begin
                fails++;
                $display("FAIL %s_latency f3=%0d a=%h b=%h got n=%0d/%0d cyc=%0d/%0d exp n=1 cyc=%0d/%0d", tag,
                         fs[n], as[n], bs[n], o.n_i, o.n_a, o.cyc_i, o.cyc_a,
                         exp_cycle(fs[n], as[n], bs[n], 1'b1), exp_cycle(fs[n], as[n], bs[n], 1'b0));
            end
            checks++;
            if (o.res_i !== e || o.res_a !== e) begin
                fails++;
                $display("FAIL %s_result f3=%0d a=%h b=%h got=%h/%h exp=%h", tag, fs[n], as[n], bs[n], o.res_i, o.res_a, e);
            end
            checks++;
            if (o.rd_i !== rd || o.rd_a !== rd) begin
                fails++;
                $display("FAIL %s_rd got=%0d/%0d exp=%0d", tag, o.rd_i, o.rd_a, rd);
            end
            checks++;
            if (o.proto_bad != 0 || o.last_i !== e || o.last_a !== e) begin
                fails++;
                $display("FAIL %s_handshake f3=%0d bad=%0d held=%h/%h exp 0 and %h", tag, fs[n], o.proto_bad,
                         o.last_i, o.last_a, e);
            end
        end
    endtask

    task automatic test_mul();
        check_ops("mul", '{3'd0, 3'd3, 3'd2, 3'd1, 3'd0},
                  '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678},
                  '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h9ABC_DEF0}, 0);
    endtask

    task automatic test_div();
        check_ops("div", '{3'd4, 3'd6, 3'd5, 3'd7},
                  '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000},
                  '{32'd2, 32'd2, 32'd3, 32'd3}, 0);
    endtask

    task automatic test_special();
        check_ops("special", '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7},
                  '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hDEAD_BEEF},
                  '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0}, 0);
    endtask

    task automatic test_flush();
        logic [31:0] before_i, before_a;
        int bad;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd4; op1 = 32'd100; op2 = 32'd7; rd_addr = 5'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy_i !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_start got busy=%b/%b exp=0/0", busy_i, busy_a);
        end
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op1 = 32'd100; op2 = 32'd7; rd_addr = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        before_i = result_i;
        before_a = result_a;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy_i !== 1'b0 || busy_a !== 1'b0 || valid_i !== 1'b0 || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle got busy=%b/%b valid=%b/%b exp=0", busy_i, busy_a, valid_i, valid_a);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (valid_i !== 1'b0 || valid_a !== 1'b0) bad++;
            if (result_i !== before_i || result_a !== before_a) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL flush_no_result got %0d bad cycles exp 0", bad);
        end
        check_ops("after_flush", '{3'd4}, '{32'hFFFF_FFF9}, '{32'd2}, 0);
    endtask

    task automatic test_busy_start();
        check_ops("busy_start", '{3'd4, 3'd7}, '{32'd1000, 32'hF000_0001}, '{32'd7, 32'd13}, 5);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op1 = 32'd1000; op2 = 32'd3; rd_addr = 5'd21;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_i, hold_i, valid_i, regs_wen_i, busy_a, hold_a, valid_a, regs_wen_a} !== 8'h00 ||
            result_i !== 32'd0 || result_a !== 32'd0 || rd_addr_i !== 5'd0 || rd_addr_a !== 5'd0) begin
            fails++;
            $display("FAIL reset_mid got busy=%b/%b res=%h/%h rd=%0d/%0d exp=all 0", busy_i, busy_a,
                     result_i, result_a, rd_addr_i, rd_addr_a);
        end
        @(negedge clk);
        rst = 1'b0;
        check_ops("after_reset", '{3'd0}, '{32'd6}, '{32'd9}, 0);
    endtask

    task automatic test_random();
        logic [2:0]  fs[24];
        logic [31:0] as[24], bs[24];
        for (int n = 0; n < 24; n++) begin
            fs[n] = 3'($urandom_range(0, 7));
            as[n] = pick();
            bs[n] = pick();
        end
        check_ops("random", fs, as, bs, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
